fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 31 +++
 rtl/fifo_wr_arb.sv | 114 +++++++++++
 tb/tb_fifo_wr_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: controller states and
// a constant-evaluable ceil(log2) used to size the owner index.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        OWN  = 2'd2
    } arb_state_e;

    // Minimum of 1 bit so a 2-requester build still has a usable index.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after
// (last winner + 1), wrapping modulo NREQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int GW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [GW-1:0]   last_i,
    output logic [GW-1:0]   idx_o,
    output logic            found_o
);

    int cand;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(last_i) + k) % NREQ;
            if (req_i[cand]) begin
                idx_o   = cand[GW-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that lets one of NREQ requesters own the write port of
// an async FIFO for a packet, bounded to MAXBURST beats per grant.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int DSIZE    = 8,
    parameter  int MAXBURST = 8,
    localparam int GW       = clog2(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ack,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [GW-1:0]         gnt_id,
    output logic                  busy
);

    arb_state_e      state_q, state_d;
    logic [GW-1:0]   gnt_id_q, gnt_id_d;
    logic [GW-1:0]   last_q, last_d;
    logic [7:0]      beat_q, beat_d;
    logic [7:0]      beat_inc;
    logic [GW-1:0]   pick_idx;
    logic            pick_found;
    logic            cur_req;
    logic            cur_last;
    logic [DSIZE-1:0] slice [NREQ];

    rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign slice[gi]   = req_data[gi*DSIZE +: DSIZE];
            assign req_ack[gi] = winc && (gnt_id_q == GW'(gi));
        end
    endgenerate

    assign cur_req  = req[gnt_id_q];
    assign cur_last = req_last[gnt_id_q];
    assign beat_inc = beat_q + 8'd1;

    // Outputs are forced quiet while reset is asserted, even mid-burst.
    assign busy   = wrst_n && (state_q == OWN);
    assign winc   = busy && cur_req && !wfull;
    assign wdata  = busy ? slice[gnt_id_q] : '0;
    assign gnt_id = gnt_id_q;

    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        last_d   = last_q;
        beat_d   = beat_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (pick_found) begin
                    gnt_id_d = pick_idx;
                    beat_d   = 8'd0;
                    state_d  = OWN;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (!cur_req) begin
                    state_d = IDLE;
                    last_d  = gnt_id_q;
                end else if (winc) begin
                    beat_d = beat_inc;
                    if (cur_last || (beat_inc == 8'(MAXBURST))) begin
                        state_d = IDLE;
                        last_d  = gnt_id_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last_q resets to NREQ-1 so requester 0 is first in line.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state_q  <= IDLE;
            gnt_id_q <= '0;
            last_q   <= GW'(NREQ - 1);
            beat_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
            beat_q   <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed packet scenarios plus randomized traffic,
// all checked every cycle against a grant/packet-level reference model.
module tb_fifo_wr_arb;

    localparam int NREQ     = 4;
    localparam int DSIZE    = 8;
    localparam int MAXBURST = 8;
    localparam int GW       = 2;

    logic                  wclk;
    logic                  wrst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ack;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [GW-1:0]         gnt_id;
    logic                  busy;

    fifo_wr_arb #(
        .NREQ     (NREQ),
        .DSIZE    (DSIZE),
        .MAXBURST (MAXBURST)
    ) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req      (req),
        .req_last (req_last),
        .req_data (req_data),
        .req_ack  (req_ack),
        .wfull    (wfull),
        .winc     (winc),
        .wdata    (wdata),
        .gnt_id   (gnt_id),
        .busy     (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 = waiting, 1 = choosing, 2 = packet in flight.
    int m_phase  = 0;
    int m_owner  = 0;
    int m_beats  = 0;
    int m_winner = NREQ - 1;

    // Observations for the directed scenarios.
    int            cyc_n;
    int            wcnt;
    int            busy_cnt;
    logic [31:0]   win_hist;
    int            grants[$];
    int            gcyc[$];
    logic          prev_busy = 1'b0;
    logic [NREQ-1:0] last_ack = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next one.
    task automatic step();
        logic            e_busy;
        logic            e_winc;
        logic [NREQ-1:0] e_ack;
        logic [DSIZE-1:0] e_wdata;
        int              cand;
        bit              hit;
        #1;
        e_busy  = wrst_n && (m_phase == 2);
        e_winc  = e_busy && req[m_owner] && !wfull;
        e_ack   = e_winc ? NREQ'(1 << m_owner) : '0;
        e_wdata = e_busy ? req_data[m_owner*DSIZE +: DSIZE] : '0;
        check("busy", 64'(busy), 64'(e_busy));
        check("winc", 64'(winc), 64'(e_winc));
        check("req_ack", 64'(req_ack), 64'(e_ack));
        check("wdata", 64'(wdata), 64'(e_wdata));
        if (e_busy) check("gnt_id", 64'(gnt_id), 64'(m_owner));

        cyc_n++;
        if (winc === 1'b1) begin
            wcnt++;
            if (cyc_n <= 32) win_hist[cyc_n-1] = 1'b1;
        end
        if (busy === 1'b1) busy_cnt++;
        if (busy === 1'b1 && prev_busy !== 1'b1) begin
            grants.push_back(int'(gnt_id));
            gcyc.push_back(cyc_n);
        end
        prev_busy = busy;
        last_ack  = req_ack;

        if (!wrst_n) begin
            m_phase  = 0;
            m_owner  = 0;
            m_beats  = 0;
            m_winner = NREQ - 1;
        end else if (m_phase == 0) begin
            if (req != '0) m_phase = 1;
        end else if (m_phase == 1) begin
            hit = 1'b0;
            for (int off = 1; off <= NREQ && !hit; off++) begin
                cand = (m_winner + off) % NREQ;
                if (req[cand]) begin
                    hit     = 1'b1;
                    m_owner = cand;
                end
            end
            m_beats = 0;
            m_phase = hit ? 2 : 0;
        end else begin
            if (!req[m_owner]) begin
                m_phase  = 0;
                m_winner = m_owner;
            end else if (e_winc) begin
                m_beats++;
                if (req_last[m_owner] || m_beats == MAXBURST) begin
                    m_phase  = 0;
                    m_winner = m_owner;
                end
            end
        end
        @(negedge wclk);
    endtask

    task automatic drv(input bit rst_n, input logic [NREQ-1:0] r, input logic [NREQ-1:0] rl, input bit wf);
        wrst_n   = rst_n;
        req      = r;
        req_last = rl;
        wfull    = wf;
        for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
        step();
    endtask

    task automatic begin_scn();
        drv(1'b0, '0, '0, 1'b0);
        cyc_n    = 0;
        wcnt     = 0;
        busy_cnt = 0;
        win_hist = '0;
        grants.delete();
        gcyc.delete();
    endtask

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        wrst_n   = 1'b0;
        req      = '0;
        req_last = '0;
        req_data = '0;
        wfull    = 1'b0;
        @(negedge wclk);

        // Three-beat packet from requester 0.
        begin_scn();
        for (int k = 1; k <= 7; k++) drv(1'b1, {3'b000, wcnt < 3}, {3'b000, wcnt == 2}, 1'b0);
        check("a_win_cycles", 64'(win_hist[6:0]), 64'(7'b0011100));
        check("a_beats", 64'(wcnt), 64'd3);
        check("a_busy_cycles", 64'(busy_cnt), 64'd3);

        // All requesting, single-beat packets: strict rotation, 3-cycle pitch.
        begin_scn();
        for (int k = 1; k <= 15; k++) drv(1'b1, 4'b1111, 4'b1111, 1'b0);
        check("b_ngrants", 64'(grants.size()), 64'd5);
        for (int i = 0; i < 5 && i < grants.size(); i++) begin
            check("b_order", 64'(grants[i]), 64'(exp_order[i]));
            check("b_grant_cycle", 64'(gcyc[i]), 64'(3 + 3*i));
        end

        // Endless packet from requester 2 is cut at MAXBURST and re-granted.
        begin_scn();
        for (int k = 1; k <= 12; k++) drv(1'b1, 4'b0100, 4'b0000, 1'b0);
        check("c_beats", 64'(wcnt), 64'(MAXBURST));
        drv(1'b1, 4'b0100, 4'b0000, 1'b0);
        check("c_ngrants", 64'(grants.size()), 64'd2);
        if (grants.size() == 2) begin
            check("c_regrant_id", 64'(grants[1]), 64'd2);
            check("c_regrant_cycle", 64'(gcyc[1]), 64'd13);
        end

        // FIFO full stalls owner 1 without losing the grant.
        begin_scn();
        for (int k = 1; k <= 10; k++) drv(1'b1, 4'b0010, 4'b0000, (k >= 4 && k <= 8));
        check("d_beats", 64'(wcnt), 64'd3);
        check("d_win_cycles", 64'(win_hist[9:0]), 64'(10'b1100000100));
        check("d_ngrants", 64'(grants.size()), 64'd1);
        check("d_busy_cycles", 64'(busy_cnt), 64'd8);

        // Owner 3 abandons; search then restarts at requester 0.
        begin_scn();
        for (int k = 1; k <= 8; k++) begin
            if (k <= 4)       drv(1'b1, 4'b1000, 4'b0000, 1'b0);
            else if (k == 5)  drv(1'b1, 4'b0000, 4'b0000, 1'b0);
            else              drv(1'b1, 4'b1111, 4'b1111, 1'b0);
        end
        check("e_beats", 64'(wcnt), 64'd3);
        check("e_ngrants", 64'(grants.size()), 64'd2);
        if (grants.size() == 2) begin
            check("e_first", 64'(grants[0]), 64'd3);
            check("e_next", 64'(grants[1]), 64'd0);
            check("e_next_cycle", 64'(gcyc[1]), 64'd8);
        end

        // Reset in the middle of owner 1's burst.
        begin_scn();
        for (int k = 1; k <= 9; k++) begin
            if (k <= 5)       drv(1'b1, 4'b0010, 4'b0000, 1'b0);
            else if (k == 6)  drv(1'b0, 4'b0010, 4'b0000, 1'b0);
            else              drv(1'b1, 4'b0011, 4'b0000, 1'b0);
        end
        check("f_beats", 64'(wcnt), 64'd4);
        check("f_busy_cycles", 64'(busy_cnt), 64'd4);
        check("f_ngrants", 64'(grants.size()), 64'd2);
        if (grants.size() == 2) begin
            check("f_after_reset_id", 64'(grants[1]), 64'd0);
            check("f_after_reset_cycle", 64'(gcyc[1]), 64'd9);
        end

        // Randomized requesters that hold data until acknowledged.
        begin_scn();
        wrst_n = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_ack[i]) begin
                    req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
                    req_last[i] = ($urandom_range(0, 3) == 0);
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
                        req_last[i] = ($urandom_range(0, 3) == 0);
                    end
                end else if ($urandom_range(0, 59) == 0) begin
                    req[i] = 1'b0;
                end
            end
            wfull  = ($urandom_range(0, 3) == 0);
            wrst_n = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
